// File: rtl/seq_arith_pkg.sv
// -----------------------------------------------------------------------------
// seq_arith_pkg
// Shared types and constants for the streaming first-difference unit.
//   buf_state_t   : occupancy of the 2-entry output buffer (EMPTY/ONE/TWO)
//   NBITS_DEFAULT : default datapath width
//   entry_t       : {diff, borrow} pairing carried through the buffer
//   BORROW_W      : 1 when SEQ_ARITH_DIFF_BORROW_EN is defined, else 0
// -----------------------------------------------------------------------------
package seq_arith_pkg;

    localparam int NBITS_DEFAULT = 8;

`ifdef SEQ_ARITH_DIFF_BORROW_EN
    localparam int BORROW_W = 1;
`else
    localparam int BORROW_W = 0;
`endif

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

    typedef struct packed {
        logic [NBITS_DEFAULT-1:0] diff;
        logic                     borrow;
    } entry_t;

endpackage

// File: rtl/seq_arith_skid_buf.sv
// -----------------------------------------------------------------------------
// seq_arith_skid_buf
// Two-entry output buffer (HEAD = output register, SKID = second entry) with a
// valid/ready handshake on both sides. in_rdy decodes only the state register,
// so it never depends combinationally on out_rdy.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   in_val/in_rdy   : upstream handshake
//   in_data [EW]    : entry to store on accept
//   out_val/out_rdy : downstream handshake
//   out_data [EW]   : HEAD entry
// -----------------------------------------------------------------------------
module seq_arith_skid_buf
    import seq_arith_pkg::*;
#(
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_val,
    output logic          in_rdy,
    input  logic [EW-1:0] in_data,
    output logic          out_val,
    input  logic          out_rdy,
    output logic [EW-1:0] out_data
);

    buf_state_t    state, state_next;
    logic [EW-1:0] head, skid;
    logic          accept, emit;

    assign accept = in_val && in_rdy;
    assign emit   = out_val && out_rdy;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= EMPTY;
        else       state <= state_next;
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (accept) state_next = ONE;
            ONE: begin
                if (accept && !emit)      state_next = TWO;
                else if (!accept && emit) state_next = EMPTY;
            end
            TWO:     if (emit) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    // outputs decoded from the state register only
    always_comb begin
        in_rdy  = (state != TWO);
        out_val = (state != EMPTY);
    end

    // HEAD/SKID storage; SKID only fills when HEAD is stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head <= '0;
            skid <= '0;
        end else begin
            case (state)
                EMPTY: if (accept) head <= in_data;
                ONE: begin
                    if (accept && emit) head <= in_data;
                    else if (accept)    skid <= in_data;
                end
                TWO:     if (emit) head <= skid;
                default: ;
            endcase
        end
    end

    assign out_data = head;

endmodule

// File: rtl/seq_arith_8b_diff.sv
// -----------------------------------------------------------------------------
// seq_arith_8b_diff
// Streaming first-difference unit (inverse of a running-sum accumulator):
// out = in_ - previous accepted in_ (mod 2^NBITS), one cycle after accept.
// Optional feature macro: SEQ_ARITH_DIFF_BORROW_EN adds out_borrow, set when
// the subtraction wrapped (in_ < base).
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   in_val/in_rdy   : input handshake (in_rdy is registered)
//   in_ [NBITS]     : running-sum sample
//   clear           : re-sync; previous sample treated as 0
//   out_val/out_rdy : output handshake
//   out [NBITS]     : difference
//   out_borrow      : wrap flag (only with SEQ_ARITH_DIFF_BORROW_EN)
// -----------------------------------------------------------------------------
module seq_arith_8b_diff
    import seq_arith_pkg::*;
#(
    parameter int NBITS = NBITS_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [NBITS-1:0] in_,
    input  logic             clear,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [NBITS-1:0] out
`ifdef SEQ_ARITH_DIFF_BORROW_EN
    ,
    output logic             out_borrow
`endif
);

    localparam int EW = NBITS + BORROW_W;

    function automatic logic [NBITS-1:0] wrap_diff(input logic [NBITS-1:0] a,
                                                   input logic [NBITS-1:0] b);
        return a - b;
    endfunction

    logic [NBITS-1:0] prev, base, diff;
    logic             accept;
    logic [EW-1:0]    entry_in, entry_out;

    assign accept = in_val && in_rdy;
    // clear on the accept cycle re-bases this very sample against zero
    assign base   = clear ? '0 : prev;
    assign diff   = wrap_diff(in_, base);

`ifdef SEQ_ARITH_DIFF_BORROW_EN
    logic borrow;
    assign borrow     = (in_ < base);
    assign entry_in   = {borrow, diff};
    assign out        = entry_out[NBITS-1:0];
    assign out_borrow = entry_out[NBITS];
`else
    assign entry_in   = diff;
    assign out        = entry_out;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       prev <= '0;
        else if (accept) prev <= in_;
        else if (clear)  prev <= '0;
    end

    seq_arith_skid_buf #(
        .EW (EW)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_data  (entry_in),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_data (entry_out)
    );

endmodule

// File: tb/tb_seq_arith_8b_diff.sv
module tb_seq_arith_8b_diff;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_val = 1'b0;
    logic       in_rdy;
    logic [7:0] in_ = 8'd0;
    logic       clear = 1'b0;
    logic       out_val;
    logic       out_rdy = 1'b1;
    logic [7:0] out;
`ifdef SEQ_ARITH_DIFF_BORROW_EN
    logic       out_borrow;
`endif

    int         total = 0;
    int         bad = 0;
    logic [8:0] sb[$];
    bit         rand_mode = 1'b0;
    logic       last_stall = 1'b0;
    logic [7:0] last_out = 8'd0;
    logic [8:0] mon_e;
    logic [7:0] acc, old, x;

    always #5 clk = ~clk;

    seq_arith_8b_diff dut (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in_     (in_),
        .clear   (clear),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out     (out)
`ifdef SEQ_ARITH_DIFF_BORROW_EN
        ,
        .out_borrow (out_borrow)
`endif
    );

    // Monitor: pops the scoreboard on every transfer, checks hold under stall
    always @(negedge clk) begin
        if (reset) begin
            last_stall = 1'b0;
        end else begin
            if (last_stall) begin
                total++;
                if (!(out_val === 1'b1 && out === last_out)) begin
                    bad++;
                    $display("FAIL hold: out_val=%0b out=%0d, required out_val=1 out=%0d",
                             out_val, out, last_out);
                end
            end
            if (out_val && out_rdy) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_out: got %0d, required no output", out);
                end else begin
                    mon_e = sb.pop_front();
                    if (out !== mon_e[7:0]) begin
                        bad++;
                        $display("FAIL diff: got %0d, required %0d", out, mon_e[7:0]);
                    end
`ifdef SEQ_ARITH_DIFF_BORROW_EN
                    total++;
                    if (out_borrow !== mon_e[8]) begin
                        bad++;
                        $display("FAIL borrow: got %0b, required %0b (diff %0d)",
                                 out_borrow, mon_e[8], mon_e[7:0]);
                    end
`endif
                end
            end
            last_stall = out_val && !out_rdy;
            last_out   = out;
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        if (rand_mode) out_rdy = ($urandom_range(0, 3) != 0);
    endtask

    // Present one sample; push its expectation when it is about to be accepted.
    // Returns one step after the accepting edge.
    task automatic send(input logic [7:0] d, input logic c, input logic [7:0] e, input logic b);
        int n;
        n = 0;
        in_val = 1'b1;
        in_    = d;
        clear  = c;
        @(negedge clk);
        while (!in_rdy && n < 64) begin
            tick;
            @(negedge clk);
            n++;
        end
        if (!in_rdy) check("send_timeout", {7'd0, in_rdy}, 8'd1);
        else         sb.push_back({b, e});
        tick;
        in_val = 1'b0;
        clear  = 1'b0;
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            tick;
            n++;
        end
        tick;
        check("drain_empty", 8'(sb.size()), 8'd0);
    endtask

    task automatic do_reset;
        in_val = 1'b0;
        clear  = 1'b0;
        reset  = 1'b1;
        #1;
        check("rst_out_val", {7'd0, out_val}, 8'd0);
        check("rst_in_rdy", {7'd0, in_rdy}, 8'd1);
        check("rst_out", out, 8'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        tick;
    endtask

    initial begin
        #1;
        do_reset;

        // basic stream, one-cycle latency, wrap on the last sample
        out_rdy = 1'b1;
        send(8'd5, 1'b0, 8'd5, 1'b0);
        check("lat_out_val", {7'd0, out_val}, 8'd1);
        check("lat_out", out, 8'd5);
        send(8'd12, 1'b0, 8'd7, 1'b0);
        send(8'd12, 1'b0, 8'd0, 1'b0);
        send(8'd3, 1'b0, 8'd247, 1'b1);
        drain;

        // backpressure: buffer fills after two accepts, third held off
        do_reset;
        out_rdy = 1'b0;
        send(8'd10, 1'b0, 8'd10, 1'b0);
        send(8'd20, 1'b0, 8'd10, 1'b0);
        check("full_in_rdy", {7'd0, in_rdy}, 8'd0);
        check("full_head", out, 8'd10);
        in_val = 1'b1;
        in_    = 8'd30;
        repeat (4) tick;
        check("held_in_rdy", {7'd0, in_rdy}, 8'd0);
        out_rdy = 1'b1;
        send(8'd30, 1'b0, 8'd10, 1'b0);
        drain;

        // clear without accept, then clear together with an accept
        do_reset;
        send(8'd50, 1'b0, 8'd50, 1'b0);
        send(8'd60, 1'b0, 8'd10, 1'b0);
        clear = 1'b1;
        tick;
        clear = 1'b0;
        send(8'd65, 1'b0, 8'd65, 1'b0);
        send(8'd70, 1'b1, 8'd70, 1'b0);
        drain;

        // reset while two entries are buffered
        do_reset;
        out_rdy = 1'b0;
        send(8'd1, 1'b0, 8'd1, 1'b0);
        send(8'd2, 1'b0, 8'd1, 1'b0);
        check("pre_rst_in_rdy", {7'd0, in_rdy}, 8'd0);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_out_val", {7'd0, out_val}, 8'd0);
        check("mid_rst_in_rdy", {7'd0, in_rdy}, 8'd1);
        sb.delete();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        tick;
        out_rdy = 1'b1;
        send(8'd9, 1'b0, 8'd9, 1'b0);
        drain;

        // wrap both ways
        do_reset;
        send(8'd255, 1'b0, 8'd255, 1'b0);
        send(8'd0, 1'b0, 8'd1, 1'b1);
        drain;

        // round trip through an accumulator with random stalls
        do_reset;
        rand_mode = 1'b1;
        acc = 8'd0;
        for (int i = 0; i < 256; i++) begin
            x   = 8'($urandom_range(0, 255));
            old = acc;
            acc = acc + x;
            send(acc, 1'b0, x, (acc < old));
        end
        drain;
        rand_mode = 1'b0;
        out_rdy   = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
